// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transmit slice: FSM state encoding and the
// default frame width, which also sets the program counter's numCycles.
package spi_pkg;

  localparam int SPI_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SHIFT    = 2'd1,
    ST_BOUNDARY = 2'd2
  } spi_state_t;

endpackage

// File: rtl/spi_tx_shifter_if.sv
// Handshake bundle between the serialClock/memory side and the SPI transmit
// stage; slave is the shifter's view, master is the driving side's view.
interface spi_tx_shifter_if #(
  parameter int dataWidth = spi_pkg::SPI_DATA_WIDTH
);

  logic                 sclkPosEdge;
  logic                 sclkNegEdge;
  logic                 txEn;
  logic [dataWidth-1:0] dataIn;
  logic                 mosi;
  logic                 csN;
  logic                 busy;
  logic                 byteDone;

  modport slave (
    input  sclkPosEdge, sclkNegEdge, txEn, dataIn,
    output mosi, csN, busy, byteDone
  );

  modport master (
    output sclkPosEdge, sclkNegEdge, txEn, dataIn,
    input  mosi, csN, busy, byteDone
  );

endinterface

// File: rtl/spi_tx_shifter_shift_reg.sv
// Loadable shift register with a registered serial output. Bit order is MSB
// first by default; defining SPI_LSB_FIRST_EN sends LSB first instead.
module spi_shift_reg
  import spi_pkg::*;
#(
  parameter int dataWidth = SPI_DATA_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 shift,
  input  logic                 clear,
  input  logic [dataWidth-1:0] dataIn,
  output logic                 serialOut
);

  logic [dataWidth-1:0] shreg;

  // serialOut always holds the bit the receiver samples on the next sclk rise
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg     <= '0;
      serialOut <= 1'b0;
    end else if (load) begin
      shreg <= dataIn;
`ifdef SPI_LSB_FIRST_EN
      serialOut <= dataIn[0];
`else
      serialOut <= dataIn[dataWidth-1];
`endif
    end else if (shift) begin
`ifdef SPI_LSB_FIRST_EN
      shreg     <= shreg >> 1;
      serialOut <= shreg[1];
`else
      shreg     <= shreg << 1;
      serialOut <= shreg[dataWidth-2];
`endif
    end else if (clear) begin
      serialOut <= 1'b0;
    end
  end

endmodule

// File: rtl/spi_tx_shifter.sv
// SPI transmit stage: frames bytes from memory onto mosi under serialClock
// strobes. Bit order follows SPI_LSB_FIRST_EN (undefined: MSB first).
module spi_tx_shifter
  import spi_pkg::*;
#(
  parameter int dataWidth = SPI_DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  spi_tx_shifter_if.slave  bus
);

  localparam int CNT_W = $clog2(dataWidth);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(dataWidth - 1);

  spi_state_t       state;
  logic [CNT_W-1:0] bitCnt;
  logic             csN;
  logic             busy;
  logic             byteDone;
  logic             mosi;

  logic negOnly;
  logic load;
  logic shift;
  logic clear;

  // A negedge strobe colliding with a posedge strobe is dropped
  assign negOnly = bus.sclkNegEdge & ~bus.sclkPosEdge;
  assign load    = negOnly & bus.txEn & ((state == ST_IDLE) | (state == ST_BOUNDARY));
  assign shift   = negOnly & (state == ST_SHIFT);
  assign clear   = negOnly & ~bus.txEn & (state == ST_BOUNDARY);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      bitCnt   <= '0;
      csN      <= 1'b1;
      busy     <= 1'b0;
      byteDone <= 1'b0;
    end else begin
      byteDone <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (load) begin
            csN    <= 1'b0;
            busy   <= 1'b1;
            bitCnt <= '0;
            state  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (bus.sclkPosEdge) begin
            if (bitCnt == LAST_BIT) begin
              byteDone <= 1'b1;
              bitCnt   <= '0;
              state    <= ST_BOUNDARY;
            end else begin
              bitCnt <= bitCnt + 1'b1;
            end
          end
        end
        ST_BOUNDARY: begin
          // txEn is only honoured here, so a frame is never cut short
          if (negOnly) begin
            if (bus.txEn) begin
              csN    <= 1'b0;
              busy   <= 1'b1;
              bitCnt <= '0;
              state  <= ST_SHIFT;
            end else begin
              csN   <= 1'b1;
              busy  <= 1'b0;
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  spi_shift_reg #(
    .dataWidth (dataWidth)
  ) shiftReg (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .shift     (shift),
    .clear     (clear),
    .dataIn    (bus.dataIn),
    .serialOut (mosi)
  );

  assign bus.mosi     = mosi;
  assign bus.csN      = csN;
  assign bus.busy     = busy;
  assign bus.byteDone = byteDone;

endmodule

// File: tb/tb_spi_tx_shifter.sv
// Scoreboard bench for spi_tx_shifter: bytes are turned into expected bit
// streams by a reference model, and a monitor checks mosi at every sclk rise.
module tb_spi_tx_shifter;
  import spi_pkg::*;

  localparam int W        = SPI_DATA_WIDTH;
  localparam int SCLK_DIV = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  spi_tx_shifter_if #(.dataWidth(W)) bus();

  spi_tx_shifter #(.dataWidth(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int testsRun       = 0;
  int testsFailed    = 0;
  int risesInFrame   = 0;
  int doneCount      = 0;
  int framesExpected = 0;
  logic monBit;
  logic expQ[$];
  logic [W-1:0] txBytes[$];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic timeoutFail(input string name);
    testsRun++;
    testsFailed++;
    $display("[TB] FAIL %s: timed out waiting, expected the event", name);
  endtask

  task automatic waitCycle();
    @(posedge clk);
    #2;
  endtask

  // Reference model: a byte is just its bits in transmission order
  function automatic void pushExpected(input logic [W-1:0] b);
    for (int i = 0; i < W; i++) begin
`ifdef SPI_LSB_FIRST_EN
      expQ.push_back(b[i]);
`else
      expQ.push_back(b[W-1-i]);
`endif
    end
    framesExpected++;
  endfunction

  // serialClock stand-in: one rise strobe and one fall strobe per period
  initial begin
    bus.sclkPosEdge = 1'b0;
    bus.sclkNegEdge = 1'b0;
    forever begin
      for (int ph = 0; ph < SCLK_DIV; ph++) begin
        @(posedge clk);
        #1;
        bus.sclkPosEdge = (ph == 0);
        bus.sclkNegEdge = (ph == SCLK_DIV / 2);
      end
    end
  end

  assert property (@(posedge clk) !(bus.sclkPosEdge && bus.sclkNegEdge))
    else $error("[TB] sclk strobes overlap");

  // Monitor: what mosi shows during a rise-strobe cycle is what gets sampled
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        expQ.delete();
        risesInFrame = 0;
      end else begin
        if (bus.sclkPosEdge && bus.csN === 1'b0) begin
          if (expQ.size() == 0) begin
            timeoutFail("unexpectedBit");
          end else begin
            monBit = expQ.pop_front();
            checkOutput("mosiBit", 32'(bus.mosi), 32'(monBit));
          end
          risesInFrame++;
        end
        if (bus.byteDone === 1'b1) begin
          checkOutput("bitsPerFrame", risesInFrame, W);
          risesInFrame = 0;
          doneCount++;
        end
      end
    end
  end

  // Streams txBytes back to back; txEn drops during the last frame once
  // dropRise bits of it have been sampled
  task automatic applyStimulus(input int dropRise);
    int n, t, cyc, lastDone, csnHigh;
    n = txBytes.size();
    cyc = 0;
    lastDone = 0;
    csnHigh = 0;
    for (int i = 0; i < n; i++) begin
      bus.dataIn = txBytes[i];
      bus.txEn   = 1'b1;
      pushExpected(txBytes[i]);
      if (i == 0) begin
        t = 0;
        while (bus.busy !== 1'b1 && t < 4 * SCLK_DIV) begin
          waitCycle();
          t++;
        end
        if (bus.busy !== 1'b1) begin
          timeoutFail("frameStart");
          bus.txEn = 1'b0;
          txBytes.delete();
          return;
        end
      end
      t = 0;
      while (t < 2 * W * SCLK_DIV) begin
        waitCycle();
        t++;
        cyc++;
        if (bus.csN !== 1'b0) csnHigh++;
        if (i == n - 1 && bus.txEn && risesInFrame >= dropRise) bus.txEn = 1'b0;
        if (bus.byteDone === 1'b1) break;
      end
      if (bus.byteDone !== 1'b1) begin
        timeoutFail("byteDone");
        bus.txEn = 1'b0;
        txBytes.delete();
        return;
      end
      if (i > 0) checkOutput("byteDoneSpacing", cyc - lastDone, W * SCLK_DIV);
      lastDone = cyc;
    end
    bus.txEn = 1'b0;
    checkOutput("csNLowInBurst", csnHigh, 0);
    t = 0;
    while (bus.csN !== 1'b1 && t < 4 * SCLK_DIV) begin
      waitCycle();
      t++;
    end
    checkOutput("csNRiseDelay", t, SCLK_DIV / 2);
    checkOutput("busyAfterBurst", 32'(bus.busy), 0);
    checkOutput("mosiAfterBurst", 32'(bus.mosi), 0);
    txBytes.delete();
  endtask

  initial begin
    int bad, t, nb;
    bus.txEn   = 1'b0;
    bus.dataIn = '0;
    rst        = 1'b1;
    repeat (3) waitCycle();
    checkOutput("resetCsN", 32'(bus.csN), 1);
    checkOutput("resetMosi", 32'(bus.mosi), 0);
    checkOutput("resetBusy", 32'(bus.busy), 0);
    checkOutput("resetByteDone", 32'(bus.byteDone), 0);
    rst = 1'b0;

    bad = 0;
    repeat (50 * SCLK_DIV) begin
      waitCycle();
      if (bus.csN !== 1'b1 || bus.mosi !== 1'b0 || bus.busy !== 1'b0 || bus.byteDone !== 1'b0)
        bad++;
    end
    checkOutput("idleViolations", bad, 0);

    txBytes.push_back(8'hA5);
    applyStimulus(W);

    txBytes.push_back(8'h3C);
    txBytes.push_back(8'hFF);
    applyStimulus(W);

    txBytes.push_back(8'h81);
    applyStimulus(3);

    // Abort a frame after its 4th rise
    bus.dataIn = W'($urandom);
    bus.txEn   = 1'b1;
    pushExpected(bus.dataIn);
    framesExpected--;
    t = 0;
    while (risesInFrame < 4 && t < 8 * SCLK_DIV) begin
      waitCycle();
      t++;
    end
    if (risesInFrame < 4) timeoutFail("midFrameRises");
    rst      = 1'b1;
    bus.txEn = 1'b0;
    waitCycle();
    checkOutput("midResetCsN", 32'(bus.csN), 1);
    checkOutput("midResetBusy", 32'(bus.busy), 0);
    rst = 1'b0;
    repeat (SCLK_DIV) waitCycle();

    txBytes.push_back(8'h5A);
    applyStimulus(W);

    txBytes.push_back(8'h01);
    applyStimulus(W);

    repeat (6) begin
      nb = $urandom_range(1, 4);
      for (int i = 0; i < nb; i++) txBytes.push_back(W'($urandom));
      applyStimulus($urandom_range(1, W));
      repeat ($urandom_range(0, 3 * SCLK_DIV)) waitCycle();
    end

    repeat (2 * SCLK_DIV) waitCycle();
    checkOutput("expQueueDrained", expQ.size(), 0);
    checkOutput("byteDoneCount", doneCount, framesExpected);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #1000000;
    testsRun++;
    testsFailed++;
    $display("[TB] FAIL watchdog: still running at %0t, expected to finish earlier", $time);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
